// File: rtl/alu_cmd_sequencer_if.sv
// Command and result valid/ready bundle for alu_cmd_sequencer.
// The sequencer connects through the slave modport, its upstream/downstream through master.
interface alu_cmd_sequencer_if #(
   parameter int unsigned TAG_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [31:0]      cmd_a;
   logic [31:0]      cmd_b;
   logic [2:0]       cmd_op;
   logic [TAG_W-1:0] cmd_tag;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_data;
   logic [2:0]       res_op;
   logic [TAG_W-1:0] res_tag;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, res_ready,
      input  cmd_ready, res_valid, res_data, res_op, res_tag
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, res_ready,
      output cmd_ready, res_valid, res_data, res_op, res_tag
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them to the registered-operand ALU and returns tagged results
// in order; result-FIFO credits bound issue so a stalled result port never drops a result.
module alu_cmd_sequencer #(
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned RES_DEPTH = 4,
   parameter int unsigned TAG_W     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_cmd_sequencer_if.slave io,
   output logic [31:0]        alu_a,
   output logic [31:0]        alu_b,
   output logic [2:0]         alu_op,
   input  logic [31:0]        alu_r,
   output logic               busy
);
   localparam int unsigned CAW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int unsigned RAW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
   localparam int unsigned RCW = $clog2(RES_DEPTH + 1);
   localparam logic [CAW:0]   CMD_FULL = (CAW + 1)'(CMD_DEPTH);
   localparam logic [RCW-1:0] RES_FULL = RCW'(RES_DEPTH);
   localparam logic [RAW-1:0] RES_LAST = RAW'(RES_DEPTH - 1);

   typedef struct packed {
      logic [31:0]      a;
      logic [31:0]      b;
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   typedef struct packed {
      logic [31:0]      data;
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
   } res_t;

   // Command FIFO
   cmd_t           cmd_mem_q [CMD_DEPTH];
   cmd_t           cmd_mem_d [CMD_DEPTH];
   logic [CAW-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d;
   logic [CAW-1:0] cmd_rd_ptr_q, cmd_rd_ptr_d;
   logic [CAW:0]   cmd_count_q, cmd_count_d;
   logic           cmd_ready_q, cmd_ready_d;

   // ALU drive registers and issue pipeline
   logic [31:0]      alu_a_q, alu_a_d;
   logic [31:0]      alu_b_q, alu_b_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic             p0_vld_q, p0_vld_d;
   logic [2:0]       p0_op_q, p0_op_d;
   logic [TAG_W-1:0] p0_tag_q, p0_tag_d;
   logic             p1_vld_q, p1_vld_d;
   logic [2:0]       p1_op_q, p1_op_d;
   logic [TAG_W-1:0] p1_tag_q, p1_tag_d;
   logic             p2_vld_q, p2_vld_d;
   logic [2:0]       p2_op_q, p2_op_d;
   logic [TAG_W-1:0] p2_tag_q, p2_tag_d;

   // Result FIFO
   res_t           res_mem_q [RES_DEPTH];
   res_t           res_mem_d [RES_DEPTH];
   logic [RAW-1:0] res_wr_ptr_q, res_wr_ptr_d;
   logic [RAW-1:0] res_rd_ptr_q, res_rd_ptr_d;
   logic [RCW-1:0] res_count_q, res_count_d;

   logic        cmd_push;
   logic        issue;
   logic        res_push;
   logic        res_pop;
   logic        res_valid;
   logic [1:0]  inflight;
   logic [31:0] credit_avail;
   logic [31:0] credit_used;
   cmd_t        cmd_head;
   res_t        res_head;

   always_comb begin
      cmd_push  = io.cmd_valid & cmd_ready_q;
      res_valid = (res_count_q != '0);
      res_pop   = res_valid & io.res_ready;
      res_push  = p2_vld_q;
      inflight  = {1'b0, p0_vld_q} + {1'b0, p1_vld_q} + {1'b0, p2_vld_q};

      // A slot freed by this edge's pop may be reused by this edge's issue.
      credit_avail = RES_DEPTH + 32'(res_pop);
      credit_used  = 32'(inflight) + 32'(res_count_q);
      issue        = (cmd_count_q != '0) && (credit_avail > credit_used);

      cmd_head = cmd_mem_q[cmd_rd_ptr_q];
      res_head = res_mem_q[res_rd_ptr_q];

      cmd_mem_d = cmd_mem_q;
      if (cmd_push) begin
         cmd_mem_d[cmd_wr_ptr_q] = {io.cmd_a, io.cmd_b, io.cmd_op, io.cmd_tag};
      end
      cmd_wr_ptr_d = cmd_wr_ptr_q + CAW'(cmd_push);
      cmd_rd_ptr_d = cmd_rd_ptr_q + CAW'(issue);
      cmd_count_d  = cmd_count_q + (CAW + 1)'(cmd_push) - (CAW + 1)'(issue);
      cmd_ready_d  = (cmd_count_d != CMD_FULL);

      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      p0_vld_d = issue;
      p0_op_d  = p0_op_q;
      p0_tag_d = p0_tag_q;
      if (issue) begin
         alu_a_d  = cmd_head.a;
         alu_b_d  = cmd_head.b;
         p0_op_d  = cmd_head.op;
         p0_tag_d = cmd_head.tag;
      end

      // Opcode trails a/b by one edge to line up with the ALU operand registers.
      alu_op_d = p0_vld_q ? p0_op_q : alu_op_q;
      p1_vld_d = p0_vld_q;
      p1_op_d  = p0_op_q;
      p1_tag_d = p0_tag_q;
      p2_vld_d = p1_vld_q;
      p2_op_d  = p1_op_q;
      p2_tag_d = p1_tag_q;

      res_mem_d = res_mem_q;
      if (res_push) begin
         res_mem_d[res_wr_ptr_q] = {alu_r, p2_op_q, p2_tag_q};
      end
      res_wr_ptr_d = res_wr_ptr_q;
      if (res_push) begin
         res_wr_ptr_d = (res_wr_ptr_q == RES_LAST) ? '0 : res_wr_ptr_q + RAW'(1);
      end
      res_rd_ptr_d = res_rd_ptr_q;
      if (res_pop) begin
         res_rd_ptr_d = (res_rd_ptr_q == RES_LAST) ? '0 : res_rd_ptr_q + RAW'(1);
      end
      res_count_d = res_count_q + RCW'(res_push) - RCW'(res_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CMD_DEPTH; i++) begin
            cmd_mem_q[i] <= '0;
         end
         for (int unsigned i = 0; i < RES_DEPTH; i++) begin
            res_mem_q[i] <= '0;
         end
         cmd_wr_ptr_q <= '0;
         cmd_rd_ptr_q <= '0;
         cmd_count_q  <= '0;
         cmd_ready_q  <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         p0_vld_q     <= 1'b0;
         p0_op_q      <= '0;
         p0_tag_q     <= '0;
         p1_vld_q     <= 1'b0;
         p1_op_q      <= '0;
         p1_tag_q     <= '0;
         p2_vld_q     <= 1'b0;
         p2_op_q      <= '0;
         p2_tag_q     <= '0;
         res_wr_ptr_q <= '0;
         res_rd_ptr_q <= '0;
         res_count_q  <= '0;
      end else begin
         cmd_mem_q    <= cmd_mem_d;
         res_mem_q    <= res_mem_d;
         cmd_wr_ptr_q <= cmd_wr_ptr_d;
         cmd_rd_ptr_q <= cmd_rd_ptr_d;
         cmd_count_q  <= cmd_count_d;
         cmd_ready_q  <= cmd_ready_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         p0_vld_q     <= p0_vld_d;
         p0_op_q      <= p0_op_d;
         p0_tag_q     <= p0_tag_d;
         p1_vld_q     <= p1_vld_d;
         p1_op_q      <= p1_op_d;
         p1_tag_q     <= p1_tag_d;
         p2_vld_q     <= p2_vld_d;
         p2_op_q      <= p2_op_d;
         p2_tag_q     <= p2_tag_d;
         res_wr_ptr_q <= res_wr_ptr_d;
         res_rd_ptr_q <= res_rd_ptr_d;
         res_count_q  <= res_count_d;
      end
   end

   assign io.cmd_ready = cmd_ready_q;
   assign io.res_valid = res_valid;
   assign io.res_data  = res_head.data;
   assign io.res_op    = res_head.op;
   assign io.res_tag   = res_head.tag;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign busy         = (cmd_count_q != '0) | (inflight != '0) | res_valid;

   // Credits make this unreachable; a push into a full FIFO without a pop would drop data.
   res_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(res_push && !res_pop && (res_count_q == RES_FULL)));
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer driving a pipelined ALU model (a/b reg, r reg).
module tb_alu_cmd_sequencer;
   localparam int unsigned TAG_W = 4;

   typedef struct packed {
      logic [31:0]      data;
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] alu_a, alu_b, alu_r;
   logic [2:0]  alu_op;
   logic        busy;
   logic [31:0] alu_ra, alu_rb;

   int   chk_cnt = 0;
   int   pass_cnt = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_cmd_sequencer_if #(.TAG_W(TAG_W)) io ();

   alu_cmd_sequencer #(.CMD_DEPTH(4), .RES_DEPTH(4), .TAG_W(TAG_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io     (io),
      .alu_a  (alu_a),
      .alu_b  (alu_b),
      .alu_op (alu_op),
      .alu_r  (alu_r),
      .busy   (busy)
   );

   function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return ~a;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return a & b;
         3'd6:    return a | b;
         default: return a ^ b;
      endcase
   endfunction

   // ALU: operands registered, result registered one edge later, no reset.
   always @(posedge clk) begin
      alu_ra <= alu_a;
      alu_rb <= alu_b;
      alu_r  <= alu_fn(alu_op, alu_ra, alu_rb);
   end

   task automatic test_reset();
      io.cmd_valid = 1'b1; io.cmd_a = 32'hDEAD_BEEF; io.cmd_b = 32'h1; io.cmd_op = 3'd1;
      io.cmd_tag = 4'hA; io.res_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++; if (io.cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready act=%b exp=0", io.cmd_ready); else pass_cnt++;
      chk_cnt++; if (io.res_valid !== 1'b0) $display("FAIL rst_res_valid act=%b exp=0", io.res_valid); else pass_cnt++;
      chk_cnt++; if ({io.res_data, io.res_op, io.res_tag} !== '0)
         $display("FAIL rst_res_fields act=%h/%h/%h exp=0", io.res_data, io.res_op, io.res_tag); else pass_cnt++;
      chk_cnt++; if ({alu_a, alu_b, alu_op} !== '0)
         $display("FAIL rst_alu_outs act=%h/%h/%h exp=0", alu_a, alu_b, alu_op); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy act=%b exp=0", busy); else pass_cnt++;
      rst_n = 1'b1; io.cmd_valid = 1'b0; io.res_ready = 1'b0;
      @(negedge clk);
      chk_cnt++; if (io.cmd_ready !== 1'b1) $display("FAIL rel_cmd_ready act=%b exp=1", io.cmd_ready); else pass_cnt++;
      chk_cnt++; if (io.res_valid !== 1'b0) $display("FAIL rel_res_valid act=%b exp=0", io.res_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rel_busy act=%b exp=0", busy); else pass_cnt++;
   endtask

   task automatic test_single_add();
      exp_t e;
      @(negedge clk);
      io.res_ready = 1'b0; io.cmd_valid = 1'b1;
      io.cmd_a = 32'd5; io.cmd_b = 32'd3; io.cmd_op = 3'd0; io.cmd_tag = 4'd1;
      chk_cnt++; if (io.cmd_ready !== 1'b1) $display("FAIL add_cmd_ready act=%b exp=1", io.cmd_ready); else pass_cnt++;
      sb.push_back('{data: 32'd8, op: 3'd0, tag: 4'd1});
      @(negedge clk);
      io.cmd_valid = 1'b0;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL add_busy act=%b exp=1", busy); else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         chk_cnt++; if (io.res_valid !== 1'b0) $display("FAIL add_early_valid_T%0d act=%b exp=0", k, io.res_valid); else pass_cnt++;
         @(negedge clk);
      end
      chk_cnt++; if (io.res_valid !== 1'b1) $display("FAIL add_latency act=%b exp=1", io.res_valid); else pass_cnt++;
      e = sb.pop_front();
      chk_cnt++; if ({io.res_data, io.res_op, io.res_tag} !== e)
         $display("FAIL add_result act=%h exp=%h", {io.res_data, io.res_op, io.res_tag}, e); else pass_cnt++;
      io.res_ready = 1'b1;
      @(negedge clk);
      io.res_ready = 1'b0;
      chk_cnt++; if (io.res_valid !== 1'b0) $display("FAIL add_drain_valid act=%b exp=0", io.res_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL add_drain_busy act=%b exp=0", busy); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [2:0]  ops [8];
      logic [31:0] va [8];
      logic [31:0] vb [8];
      logic [31:0] vr [8];
      ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      va  = '{32'hFFFF_FFFF, 32'h0, 32'h0000_FFFF, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
              32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
      vb  = '{32'h1, 32'h1, 32'h0, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00,
              32'hFF00_FF00, 32'hFF00_FF00};
      vr  = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0FFF_0FFF, 32'h000F_000F,
              32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0};
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               io.cmd_valid = 1'b1; io.cmd_a = va[i]; io.cmd_b = vb[i];
               io.cmd_op = ops[i]; io.cmd_tag = TAG_W'(i);
               chk_cnt++; if (io.cmd_ready !== 1'b1) $display("FAIL b2b_cmd_ready_%0d act=%b exp=1", i, io.cmd_ready); else pass_cnt++;
               sb.push_back('{data: vr[i], op: ops[i], tag: TAG_W'(i)});
            end
            @(negedge clk);
            io.cmd_valid = 1'b0;
         end
         begin
            int waited = 0;
            exp_t e;
            io.res_ready = 1'b1;
            while (!io.res_valid && waited < 20) begin
               @(negedge clk);
               waited++;
            end
            chk_cnt++; if (io.res_valid !== 1'b1) $display("FAIL b2b_first_timeout act=%b exp=1", io.res_valid); else pass_cnt++;
            for (int i = 0; i < 8; i++) begin
               chk_cnt++; if (io.res_valid !== 1'b1) $display("FAIL b2b_gap_%0d act=%b exp=1", i, io.res_valid); else pass_cnt++;
               if (io.res_valid && sb.size() > 0) begin
                  e = sb.pop_front();
                  chk_cnt++; if ({io.res_data, io.res_op, io.res_tag} !== e)
                     $display("FAIL b2b_result_%0d act=%h exp=%h", i, {io.res_data, io.res_op, io.res_tag}, e); else pass_cnt++;
               end
               @(negedge clk);
            end
            io.res_ready = 1'b0;
         end
      join
      repeat (2) @(negedge clk);
      chk_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy act=%b exp=0", busy); else pass_cnt++;
      chk_cnt++; if (sb.size() != 0) $display("FAIL b2b_leftover act=%0d exp=0", sb.size()); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [31:0] va [10];
      logic [31:0] vb [10];
      logic [2:0]  vo [10];
      int accepted = 0;
      for (int i = 0; i < 10; i++) begin
         va[i] = $urandom; vb[i] = $urandom; vo[i] = 3'($urandom_range(7, 0));
      end
      io.res_ready = 1'b0;
      fork
         begin
            int cyc = 0;
            while (accepted < 10 && cyc < 200) begin
               @(negedge clk);
               cyc++;
               io.cmd_valid = 1'b1; io.cmd_a = va[accepted]; io.cmd_b = vb[accepted];
               io.cmd_op = vo[accepted]; io.cmd_tag = TAG_W'(accepted);
               if (io.cmd_ready) begin
                  sb.push_back('{data: alu_fn(vo[accepted], va[accepted], vb[accepted]),
                                 op: vo[accepted], tag: TAG_W'(accepted)});
                  accepted++;
               end
            end
            @(negedge clk);
            io.cmd_valid = 1'b0;
            chk_cnt++; if (accepted != 10) $display("FAIL bp_send_timeout act=%0d exp=10", accepted); else pass_cnt++;
         end
         begin
            int n = 0;
            int cyc = 0;
            exp_t e;
            repeat (20) @(negedge clk);
            chk_cnt++; if (accepted != 8) $display("FAIL bp_accepted act=%0d exp=8", accepted); else pass_cnt++;
            chk_cnt++; if (io.cmd_ready !== 1'b0) $display("FAIL bp_cmd_ready act=%b exp=0", io.cmd_ready); else pass_cnt++;
            chk_cnt++; if (io.res_valid !== 1'b1) $display("FAIL bp_res_valid act=%b exp=1", io.res_valid); else pass_cnt++;
            chk_cnt++; if (busy !== 1'b1) $display("FAIL bp_busy act=%b exp=1", busy); else pass_cnt++;
            io.res_ready = 1'b1;
            while (n < 10 && cyc < 200) begin
               if (io.res_valid) begin
                  if (sb.size() == 0) begin
                     chk_cnt++; $display("FAIL bp_unexpected act=%h exp=none", {io.res_data, io.res_op, io.res_tag});
                  end else begin
                     e = sb.pop_front();
                     chk_cnt++; if ({io.res_data, io.res_op, io.res_tag} !== e)
                        $display("FAIL bp_result_%0d act=%h exp=%h", n, {io.res_data, io.res_op, io.res_tag}, e); else pass_cnt++;
                  end
                  n++;
               end
               @(negedge clk);
               cyc++;
            end
            chk_cnt++; if (n != 10) $display("FAIL bp_recv_timeout act=%0d exp=10", n); else pass_cnt++;
         end
      join
      repeat (6) @(negedge clk);
      chk_cnt++; if (io.res_valid !== 1'b0) $display("FAIL bp_extra_result act=%b exp=0", io.res_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL bp_idle_busy act=%b exp=0", busy); else pass_cnt++;
      io.res_ready = 1'b0;
   endtask

   task automatic test_reset_midop();
      io.res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         io.cmd_valid = 1'b1; io.cmd_a = 32'h100 + i; io.cmd_b = 32'h7; io.cmd_op = 3'd0;
         io.cmd_tag = TAG_W'(i);
         chk_cnt++; if (io.cmd_ready !== 1'b1) $display("FAIL mid_cmd_ready_%0d act=%b exp=1", i, io.cmd_ready); else pass_cnt++;
      end
      @(negedge clk);
      io.cmd_valid = 1'b0;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_before act=%b exp=1", busy); else pass_cnt++;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk_cnt++; if (io.res_valid !== 1'b0) $display("FAIL mid_res_valid_%0d act=%b exp=0", k, io.res_valid); else pass_cnt++;
         chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy_%0d act=%b exp=0", k, busy); else pass_cnt++;
      end
      chk_cnt++; if (io.cmd_ready !== 1'b1) $display("FAIL mid_cmd_ready_after act=%b exp=1", io.cmd_ready); else pass_cnt++;
   endtask

   task automatic test_random();
      int sent = 0;
      int got = 0;
      int cov_cmd_full = 0;
      int cov_res_empty = 0;
      int cov_res_stall = 0;
      fork
         begin
            int cyc = 0;
            bit taken = 1'b0;
            io.cmd_valid = 1'b0;
            while (sent < 1000 && cyc < 30000) begin
               @(negedge clk);
               cyc++;
               if (!io.cmd_valid || taken) begin
                  io.cmd_valid = 1'($urandom_range(1, 0));
                  io.cmd_a = $urandom; io.cmd_b = $urandom;
                  io.cmd_op = 3'($urandom_range(7, 0)); io.cmd_tag = TAG_W'($urandom_range(15, 0));
               end
               taken = 1'b0;
               if (!io.cmd_ready) cov_cmd_full++;
               if (io.cmd_valid && io.cmd_ready) begin
                  sb.push_back('{data: alu_fn(io.cmd_op, io.cmd_a, io.cmd_b), op: io.cmd_op, tag: io.cmd_tag});
                  sent++;
                  taken = 1'b1;
               end
            end
            @(negedge clk);
            io.cmd_valid = 1'b0;
            chk_cnt++; if (sent != 1000) $display("FAIL rnd_send_timeout act=%0d exp=1000", sent); else pass_cnt++;
         end
         begin
            int cyc = 0;
            exp_t e;
            while (got < 1000 && cyc < 30000) begin
               @(negedge clk);
               cyc++;
               io.res_ready = 1'($urandom_range(1, 0));
               if (!io.res_valid) cov_res_empty++;
               if (io.res_valid && !io.res_ready) cov_res_stall++;
               if (io.res_valid && io.res_ready) begin
                  if (sb.size() == 0) begin
                     chk_cnt++; $display("FAIL rnd_unexpected act=%h exp=none", {io.res_data, io.res_op, io.res_tag});
                  end else begin
                     e = sb.pop_front();
                     chk_cnt++; if ({io.res_data, io.res_op, io.res_tag} !== e)
                        $display("FAIL rnd_result_%0d act=%h exp=%h", got, {io.res_data, io.res_op, io.res_tag}, e); else pass_cnt++;
                  end
                  got++;
               end
            end
            @(negedge clk);
            io.res_ready = 1'b0;
            chk_cnt++; if (got != 1000) $display("FAIL rnd_recv_timeout act=%0d exp=1000", got); else pass_cnt++;
         end
      join
      chk_cnt++; if (sb.size() != 0) $display("FAIL rnd_leftover act=%0d exp=0", sb.size()); else pass_cnt++;
      $display("coverage: cmd_full_cycles=%0d res_empty_cycles=%0d res_stall_cycles=%0d",
               cov_cmd_full, cov_res_empty, cov_res_stall);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      io.cmd_valid = 1'b0; io.cmd_a = '0; io.cmd_b = '0; io.cmd_op = '0; io.cmd_tag = '0;
      io.res_ready = 1'b0;
      test_reset();
      test_single_add();
      test_back_to_back();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
